conv2d_stream_engine: RTL and testbench

Streaming 3x3 valid-mode 2-D convolution engine for a raster-ordered single-channel IFM.
- Generalises the fixed 14x14 / 16-bit convolution path: image size and data width are parameters, weights are reloadable, pixel input has a ready/valid handshake, and end-of-frame is signalled.
- Sits between the IFM source and the OFM writer / pooling stage.

---
 rtl/conv2d_stream_engine_pkg.sv | 13 +
 rtl/conv2d_stream_engine_mac9.sv | 48 ++++
 rtl/conv2d_stream_engine.sv | 198 +++++++++++++++++++
 tb/tb_conv2d_stream_engine.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv2d_stream_engine_pkg.sv
// Shared types and constants for the 3x3 streaming convolution engine.
package conv_pkg;

  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

  localparam int unsigned KSIZE = 3;
  localparam int unsigned NTAPS = KSIZE * KSIZE;

  function automatic int unsigned acc_width(input int unsigned data_w);
    return 2 * data_w + 4;
  endfunction

endpackage

// File: rtl/conv2d_stream_engine_mac9.sv
// 9-tap signed multiply-add: product register, then sign-extended sum register.
module conv_mac9
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = acc_width(DATA_W)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [NTAPS-1:0][DATA_W-1:0]  pix,
  input  logic [NTAPS-1:0][DATA_W-1:0]  wts,
  output logic signed [ACC_W-1:0]       result,
  output logic                          valid
);

  logic signed [2*DATA_W-1:0] prod [NTAPS];
  logic                       prod_valid;
  logic signed [ACC_W-1:0]    sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NTAPS; k++) prod[k] <= '0;
      prod_valid <= 1'b0;
    end else begin
      prod_valid <= in_valid;
      if (in_valid)
        for (int unsigned k = 0; k < NTAPS; k++)
          prod[k] <= (2*DATA_W)'($signed(pix[k])) * (2*DATA_W)'($signed(wts[k]));
    end
  end

  always_comb begin
    sum = '0;
    for (int unsigned k = 0; k < NTAPS; k++) sum = sum + ACC_W'(prod[k]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= prod_valid;
      if (prod_valid) result <= sum;
    end
  end

endmodule

// File: rtl/conv2d_stream_engine.sv
// Streaming 3x3 valid-mode convolution over a raster IFM with reloadable weights.
// Optional 2x2 stride-2 max-pool on the results when CONV_MAXPOOL_EN is defined.
module conv2d_stream_engine
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W  = 14,
  parameter int unsigned IMG_H  = 14,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = acc_width(DATA_W)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     w_valid,
  input  logic [DATA_W-1:0]        w_data,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic signed [ACC_W-1:0]  out_data,
  output logic                     out_last,
  output logic                     busy
);

  localparam int unsigned DEPTH = 2 * IMG_W + 3;
  localparam int unsigned CW    = $clog2(IMG_W);
  localparam int unsigned RW    = $clog2(IMG_H);
`ifdef CONV_MAXPOOL_EN
  localparam int unsigned DRAIN_CYC = 3;
`else
  localparam int unsigned DRAIN_CYC = 2;
`endif

  state_t                       state, state_next;
  logic [DATA_W-1:0]            sr [DEPTH];
  logic [NTAPS-1:0][DATA_W-1:0] wts, win;
  logic [3:0]                   w_idx;
  logic [CW-1:0]                col;
  logic [RW-1:0]                row;
  logic [1:0]                   drain_cnt;
  logic                         accept, is_last, w_we;
  logic                         win_valid, win_last, last_d1, last_d2;
  logic signed [ACC_W-1:0]      mac_result;
  logic                         mac_valid;

  assign accept  = in_valid && in_ready;
  assign is_last = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));

  always_comb begin
    state_next = state;
    w_we       = 1'b0;
    case (state)
      IDLE: begin
        if (w_valid) begin
          w_we       = 1'b1;
          state_next = LOAD_W;
        end else if (in_valid) begin
          state_next = STREAM;
        end
      end
      LOAD_W: begin
        if (w_valid) begin
          w_we = 1'b1;
          if (w_idx == 4'(NTAPS - 1)) state_next = STREAM;
        end
      end
      STREAM:  if (accept && is_last) state_next = DRAIN;
      DRAIN:   if (drain_cnt == 2'(DRAIN_CYC - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      w_idx     <= '0;
      drain_cnt <= '0;
      wts       <= '0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == STREAM);
      busy      <= (state != IDLE);
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : '0;
      if (w_we) begin
        wts[w_idx] <= w_data;
        w_idx      <= (w_idx == 4'(NTAPS - 1)) ? '0 : w_idx + 4'd1;
      end
    end
  end

  // sr[0] is the newest pixel; window tap (i,j) lies (2-i) rows and (2-j) pixels back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) sr[k] <= '0;
      col       <= '0;
      row       <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      last_d1   <= 1'b0;
      last_d2   <= 1'b0;
    end else begin
      win_valid <= accept && (row >= RW'(2)) && (col >= CW'(2));
      win_last  <= accept && is_last;
      last_d1   <= win_last;
      last_d2   <= last_d1;
      if (accept) begin
        sr[0] <= in_data;
        for (int unsigned k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
        if (col == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= is_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else if (state == IDLE) begin
        col <= '0;
        row <= '0;
      end
    end
  end

  always_comb begin
    win = '0;
    for (int unsigned i = 0; i < KSIZE; i++)
      for (int unsigned j = 0; j < KSIZE; j++)
        win[KSIZE*i + j] = sr[(KSIZE-1-i)*IMG_W + (KSIZE-1-j)];
  end

  conv_mac9 #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (win_valid),
    .pix      (win),
    .wts      (wts),
    .result   (mac_result),
    .valid    (mac_valid)
  );

`ifdef CONV_MAXPOOL_EN
  localparam int unsigned PW = (IMG_W - 2) / 2;

  if (((IMG_W - 2) % 2 != 0) || ((IMG_H - 2) % 2 != 0)) begin : g_pool_size_chk
    $error("conv2d_stream_engine: max-pool needs even (IMG_W-2) and (IMG_H-2)");
  end

  logic signed [ACC_W-1:0] rowbuf [PW];
  logic signed [ACC_W-1:0] hold, pair_max, quad_max;
  logic [CW-1:0]           oc;
  logic [RW-1:0]           orow;
  logic [CW-2:0]           pidx;

  // Even columns park in hold, even rows park pair maxima in rowbuf, odd/odd emits.
  assign pidx     = oc[CW-1:1];
  assign pair_max = (hold > mac_result) ? hold : mac_result;
  assign quad_max = (rowbuf[pidx] > pair_max) ? rowbuf[pidx] : pair_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < PW; k++) rowbuf[k] <= '0;
      hold      <= '0;
      oc        <= '0;
      orow      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      if (mac_valid) begin
        if (!oc[0]) begin
          hold <= mac_result;
        end else if (!orow[0]) begin
          rowbuf[pidx] <= pair_max;
        end else begin
          out_valid <= 1'b1;
          out_data  <= quad_max;
          out_last  <= last_d2;
        end
        if (oc == CW'(IMG_W - 3)) begin
          oc   <= '0;
          orow <= last_d2 ? '0 : orow + 1'b1;
        end else begin
          oc <= oc + 1'b1;
        end
      end
    end
  end
`else
  assign out_valid = mac_valid;
  assign out_data  = mac_result;
  assign out_last  = last_d2;
`endif

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Self-checking bench for conv2d_stream_engine on a 4x4 frame; model follows CONV_MAXPOOL_EN.
module tb_conv2d_stream_engine;

  localparam int unsigned IMG_W  = 4;
  localparam int unsigned IMG_H  = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ACC_W  = 2 * DATA_W + 4;
  localparam int          NPIX   = IMG_W * IMG_H;
`ifdef CONV_MAXPOOL_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              w_valid = 1'b0;
  logic [DATA_W-1:0] w_data = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready, out_valid, out_last, busy;
  logic [ACC_W-1:0]  out_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DATA_W-1:0] wts_m [9];
  logic [DATA_W-1:0] pix_m [NPIX];
  int                acc_edge [NPIX];
  logic [ACC_W-1:0]  exp_data [$];
  int                exp_trig [$];
  logic [ACC_W-1:0]  obs_data [$];
  logic              obs_last [$];
  int                obs_cyc  [$];

  conv2d_stream_engine #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .w_valid   (w_valid),
    .w_data    (w_data),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      obs_data.push_back(out_data);
      obs_last.push_back(out_last);
      obs_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: full-precision 2-D convolution over the image, optionally 2x2 max-pooled.
  task automatic build_expected();
    logic signed [63:0] conv [IMG_H-2][IMG_W-2];
    logic signed [63:0] s;
    exp_data.delete();
    exp_trig.delete();
    for (int r = 0; r < IMG_H - 2; r++)
      for (int c = 0; c < IMG_W - 2; c++) begin
        s = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            s = s + longint'($signed(wts_m[3*i+j])) * longint'($signed(pix_m[(r+i)*IMG_W + c + j]));
        conv[r][c] = s;
      end
`ifdef CONV_MAXPOOL_EN
    for (int pr = 0; pr < (IMG_H - 2) / 2; pr++)
      for (int pc = 0; pc < (IMG_W - 2) / 2; pc++) begin
        s = conv[2*pr][2*pc];
        if (conv[2*pr][2*pc+1] > s)   s = conv[2*pr][2*pc+1];
        if (conv[2*pr+1][2*pc] > s)   s = conv[2*pr+1][2*pc];
        if (conv[2*pr+1][2*pc+1] > s) s = conv[2*pr+1][2*pc+1];
        exp_data.push_back(s[ACC_W-1:0]);
        exp_trig.push_back((2*pr + 3) * IMG_W + 2*pc + 3);
      end
`else
    for (int r = 0; r < IMG_H - 2; r++)
      for (int c = 0; c < IMG_W - 2; c++) begin
        s = conv[r][c];
        exp_data.push_back(s[ACC_W-1:0]);
        exp_trig.push_back((r + 2) * IMG_W + c + 2);
      end
`endif
  endtask

  task automatic load_weights(input bit with_pixel);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k == 1 && with_pixel) check("wv_iv_load_wins", {63'd0, in_ready}, 64'd0);
      if (k > 0 && $urandom_range(0, 3) == 0) begin
        w_valid = 1'b0;
        @(negedge clk);
      end
      w_valid  = 1'b1;
      w_data   = wts_m[k];
      in_valid = (k == 0) ? with_pixel : 1'b0;
      in_data  = DATA_W'($urandom);
    end
    @(negedge clk);
    w_valid  = 1'b0;
    in_valid = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random bubbles plus junk w_valid
  task automatic send_frame(input int mode, input int npix);
    int  idx   = 0;
    int  guard = 0;
    bit  drive;
    obs_data.delete();
    obs_last.delete();
    obs_cyc.delete();
    while (idx < npix && guard < 400) begin
      @(negedge clk);
      guard++;
      case (mode)
        0:       drive = 1'b1;
        1:       drive = (guard % 2 == 1);
        default: drive = ($urandom_range(0, 2) != 0);
      endcase
      in_valid = drive;
      in_data  = drive ? pix_m[idx] : DATA_W'($urandom);
      if (mode == 2 && in_ready) begin
        w_valid = $urandom_range(0, 1) == 1;
        w_data  = DATA_W'($urandom);
      end else begin
        w_valid = 1'b0;
      end
      if (drive && in_ready) begin
        acc_edge[idx] = cyc + 1;
        idx++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    w_valid  = 1'b0;
    check("frame_accept_count", 64'(idx), 64'(npix));
  endtask

  task automatic check_frame(input string tag);
    int n;
    repeat (LAT + 3) @(negedge clk);
    check({tag, "_count"}, 64'(obs_data.size()), 64'(exp_data.size()));
    n = (obs_data.size() < exp_data.size()) ? obs_data.size() : exp_data.size();
    for (int k = 0; k < n; k++) begin
      check({tag, "_data"}, 64'(obs_data[k]), 64'(exp_data[k]));
      check({tag, "_last"}, {63'd0, obs_last[k]}, {63'd0, k == exp_data.size() - 1});
      check({tag, "_latency"}, 64'(obs_cyc[k]), 64'(acc_edge[exp_trig[k]] + LAT));
    end
    check({tag, "_busy_idle"}, {63'd0, busy}, 64'd0);
    check({tag, "_ready_idle"}, {63'd0, in_ready}, 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
    check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_out_data"}, 64'(out_data), 64'd0);
    check({tag, "_out_last"}, {63'd0, out_last}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic set_const(input logic [DATA_W-1:0] w, input logic [DATA_W-1:0] p);
    for (int k = 0; k < 9; k++) wts_m[k] = w;
    for (int k = 0; k < NPIX; k++) pix_m[k] = p;
  endtask

  task automatic set_ramp_ones();
    for (int k = 0; k < 9; k++) wts_m[k] = DATA_W'(1);
    for (int k = 0; k < NPIX; k++) pix_m[k] = DATA_W'(k + 1);
  endtask

  task automatic set_random();
    for (int k = 0; k < 9; k++) wts_m[k] = DATA_W'($urandom);
    for (int k = 0; k < NPIX; k++) pix_m[k] = DATA_W'($urandom);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("idle");

    // ramp frame, all-ones weights, back-to-back
    set_ramp_ones();
    load_weights(1'b0);
    build_expected();
    send_frame(0, NPIX);
    check_frame("ramp_b2b");

    // same frame with a bubble every other cycle, weights reused
    send_frame(1, NPIX);
    check_frame("ramp_gaps");

    // second frame with no reload
    send_frame(0, NPIX);
    check_frame("ramp_reuse");

    // sign-extension extremes
    set_const(16'hFFFF, 16'h7FFF);
    load_weights(1'b0);
    build_expected();
    send_frame(0, NPIX);
    check_frame("neg_ext");

    set_const(16'h8000, 16'h8000);
    load_weights(1'b0);
    build_expected();
    send_frame(0, NPIX);
    check_frame("min_min");

    // w_valid and in_valid together in IDLE
    set_random();
    load_weights(1'b1);
    build_expected();
    send_frame(0, NPIX);
    check_frame("load_wins");

    // reset mid-frame discards the frame and clears the weights
    set_ramp_ones();
    load_weights(1'b0);
    send_frame(0, 7);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("post_reset");
    for (int k = 0; k < 9; k++) wts_m[k] = '0;
    for (int k = 0; k < NPIX; k++) pix_m[k] = DATA_W'($urandom);
    build_expected();
    send_frame(0, NPIX);
    check_frame("cleared_wts");

    set_ramp_ones();
    load_weights(1'b0);
    build_expected();
    send_frame(0, NPIX);
    check_frame("after_reset");

    // random weights and pixels with random bubbles
    for (int t = 0; t < 4; t++) begin
      set_random();
      load_weights(1'b0);
      build_expected();
      send_frame(2, NPIX);
      check_frame("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
